// File: rtl/sd_ctrl_pkg.sv
// Shared constants for the SPI-mode SD single-block engine: state codes,
// SD command/token bytes, error codes and the block-address helper.
package sd_ctrl_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE   = 4'd0;
    localparam state_t ST_CMD    = 4'd1;
    localparam state_t ST_R1     = 4'd2;
    localparam state_t ST_GAP    = 4'd3;
    localparam state_t ST_TOKEN  = 4'd4;
    localparam state_t ST_DATA   = 4'd5;
    localparam state_t ST_CRC    = 4'd6;
    localparam state_t ST_RESP   = 4'd7;
    localparam state_t ST_BUSY   = 4'd8;
    localparam state_t ST_FINISH = 4'd9;

    localparam logic [7:0] CMD17       = 8'h51;
    localparam logic [7:0] CMD24       = 8'h58;
    localparam logic [7:0] TOKEN_START = 8'hFE;
    localparam logic [7:0] FILL_BYTE   = 8'hFF;

    localparam int BLOCK_LEN = 512;

    typedef enum logic [2:0] {
        ERR_NONE          = 3'd0,
        ERR_R1_TIMEOUT    = 3'd1,
        ERR_R1_STATUS     = 3'd2,
        ERR_TOKEN_TIMEOUT = 3'd3,
        ERR_TOKEN_ERROR   = 3'd4,
        ERR_WRITE_REJECT  = 3'd5,
        ERR_BUSY_TIMEOUT  = 3'd6
    } err_code_t;

    // Standard-capacity cards take a byte address, SDHC takes the block number.
    function automatic logic [31:0] sd_arg(input logic [31:0] lba, input logic high_cap);
        return high_cap ? lba : {lba[22:0], 9'd0};
    endfunction

endpackage

// File: rtl/sd_block_ctrl_if.sv
// Host, data side-port and spiMaster signals of the SD block engine.
// slave is the engine's view, master is the surrounding system's view.
interface sd_block_ctrl_if;

    logic        start;
    logic        write;
    logic [31:0] lba;
    logic        high_cap;
    logic        busy;
    logic        done;
    logic        err;
    logic [2:0]  err_code;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic [7:0]  wr_data;
    logic        wr_take;
    logic        spi_send;
    logic [7:0]  spi_tx;
    logic [7:0]  spi_rx;
    logic        spi_avail;
    logic        spi_busy;
    logic        sd_cs;

    modport master (
        output start, write, lba, high_cap, wr_data, spi_rx, spi_avail, spi_busy,
        input  busy, done, err, err_code, rd_data, rd_valid, wr_take, spi_send, spi_tx, sd_cs
    );

    modport slave (
        input  start, write, lba, high_cap, wr_data, spi_rx, spi_avail, spi_busy,
        output busy, done, err, err_code, rd_data, rd_valid, wr_take, spi_send, spi_tx, sd_cs
    );

endinterface

// File: rtl/sd_byte_xfer.sv
// One full-duplex byte exchange with spiMaster: latch tx on req, pulse send
// once spiMaster is idle, then return the received byte with a one-cycle ack.
module sd_byte_xfer (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [7:0] tx,
    output logic       ack,
    output logic [7:0] rx,
    output logic       spi_send,
    output logic [7:0] spi_tx,
    input  logic [7:0] spi_rx,
    input  logic       spi_avail,
    input  logic       spi_busy
);

    logic pending;
    logic inflight;

    // spi_send doubles as the guard for the cycle after a pulse, when spiMaster's busy flag may still read low.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= 1'b0;
            inflight <= 1'b0;
            ack      <= 1'b0;
            rx       <= 8'h00;
            spi_send <= 1'b0;
            spi_tx   <= 8'hFF;
        end else begin
            spi_send <= 1'b0;
            ack      <= 1'b0;
            if (req && !pending && !inflight) begin
                spi_tx  <= tx;
                pending <= 1'b1;
            end
            if (pending && !spi_busy && !spi_send) begin
                spi_send <= 1'b1;
                pending  <= 1'b0;
                inflight <= 1'b1;
            end
            if (inflight && !spi_send && spi_avail) begin
                rx       <= spi_rx;
                ack      <= 1'b1;
                inflight <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sd_block_ctrl.sv
// SPI-mode SD single-block read (CMD17) / write (CMD24) sequencer driving the
// byte-level spiMaster; owns chip select for the whole transfer.
module sd_block_ctrl
    import sd_ctrl_pkg::*;
#(
    parameter int R1_POLLS    = 8,
    parameter int TOKEN_POLLS = 4096,
    parameter int BUSY_POLLS  = 65535
) (
    input logic           clk,
    input logic           rst,
    sd_block_ctrl_if.slave bus
);

    localparam logic [15:0] R1_LAST    = 16'(R1_POLLS - 1);
    localparam logic [15:0] TOKEN_LAST = 16'(TOKEN_POLLS - 1);
    localparam logic [15:0] BUSY_LAST  = 16'(BUSY_POLLS - 1);
    localparam logic [8:0]  DATA_LAST  = 9'(BLOCK_LEN - 1);

    state_t      state;
    err_code_t   err_code_r;
    logic        wr_op;
    logic [31:0] arg;
    logic        busy_r;
    logic        done_r;
    logic        err_r;
    logic        sd_cs_r;
    logic        wait_ack;
    logic        req;
    logic [7:0]  tx;
    logic [7:0]  tx_next;
    logic [8:0]  byte_cnt;
    logic [15:0] poll_cnt;
    logic        ack;
    logic [7:0]  rx;
    logic        spi_send;
    logic [7:0]  spi_tx;

    sd_byte_xfer xfer (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .tx        (tx),
        .ack       (ack),
        .rx        (rx),
        .spi_send  (spi_send),
        .spi_tx    (spi_tx),
        .spi_rx    (bus.spi_rx),
        .spi_avail (bus.spi_avail),
        .spi_busy  (bus.spi_busy)
    );

    always_comb begin
        tx_next = FILL_BYTE;
        case (state)
            ST_CMD: begin
                case (byte_cnt[2:0])
                    3'd0:    tx_next = wr_op ? CMD24 : CMD17;
                    3'd1:    tx_next = arg[31:24];
                    3'd2:    tx_next = arg[23:16];
                    3'd3:    tx_next = arg[15:8];
                    3'd4:    tx_next = arg[7:0];
                    default: tx_next = FILL_BYTE;
                endcase
            end
            ST_TOKEN: if (wr_op) tx_next = TOKEN_START;
            ST_DATA:  if (wr_op) tx_next = bus.wr_data;
            default:  tx_next = FILL_BYTE;
        endcase
    end

    // Each non-idle state issues one exchange, then decides on its ack; every error lands in FINISH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            err_code_r <= ERR_NONE;
            wr_op      <= 1'b0;
            arg        <= 32'h0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            sd_cs_r    <= 1'b1;
            wait_ack   <= 1'b0;
            req        <= 1'b0;
            tx         <= FILL_BYTE;
            byte_cnt   <= 9'd0;
            poll_cnt   <= 16'd0;
        end else begin
            req    <= 1'b0;
            done_r <= 1'b0;
            if (state == ST_IDLE) begin
                if (bus.start && !done_r) begin
                    wr_op      <= bus.write;
                    arg        <= sd_arg(bus.lba, bus.high_cap);
                    busy_r     <= 1'b1;
                    sd_cs_r    <= 1'b0;
                    err_code_r <= ERR_NONE;
                    err_r      <= 1'b0;
                    state      <= ST_CMD;
                    byte_cnt   <= 9'd0;
                    poll_cnt   <= 16'd0;
                    wait_ack   <= 1'b0;
                end
            end else if (!wait_ack) begin
                req      <= 1'b1;
                tx       <= tx_next;
                wait_ack <= 1'b1;
            end else if (ack) begin
                wait_ack <= 1'b0;
                case (state)
                    ST_CMD: begin
                        if (byte_cnt == 9'd5) begin
                            state    <= ST_R1;
                            poll_cnt <= 16'd0;
                        end else begin
                            byte_cnt <= byte_cnt + 9'd1;
                        end
                    end
                    ST_R1: begin
                        if (!rx[7]) begin
                            if (rx != 8'h00) begin
                                err_code_r <= ERR_R1_STATUS;
                                state      <= ST_FINISH;
                            end else begin
                                state    <= wr_op ? ST_GAP : ST_TOKEN;
                                poll_cnt <= 16'd0;
                            end
                        end else if (poll_cnt == R1_LAST) begin
                            err_code_r <= ERR_R1_TIMEOUT;
                            state      <= ST_FINISH;
                        end else begin
                            poll_cnt <= poll_cnt + 16'd1;
                        end
                    end
                    ST_GAP: state <= ST_TOKEN;
                    ST_TOKEN: begin
                        if (wr_op || rx == TOKEN_START) begin
                            state    <= ST_DATA;
                            byte_cnt <= 9'd0;
                        end else if (rx[7:4] == 4'h0) begin
                            err_code_r <= ERR_TOKEN_ERROR;
                            state      <= ST_FINISH;
                        end else if (poll_cnt == TOKEN_LAST) begin
                            err_code_r <= ERR_TOKEN_TIMEOUT;
                            state      <= ST_FINISH;
                        end else begin
                            poll_cnt <= poll_cnt + 16'd1;
                        end
                    end
                    ST_DATA: begin
                        if (byte_cnt == DATA_LAST) begin
                            state    <= ST_CRC;
                            byte_cnt <= 9'd0;
                        end else begin
                            byte_cnt <= byte_cnt + 9'd1;
                        end
                    end
                    ST_CRC: begin
                        if (byte_cnt == 9'd1) state <= wr_op ? ST_RESP : ST_FINISH;
                        else byte_cnt <= byte_cnt + 9'd1;
                    end
                    ST_RESP: begin
                        if ((rx & 8'h1F) != 8'h05) begin
                            err_code_r <= ERR_WRITE_REJECT;
                            state      <= ST_FINISH;
                        end else begin
                            state    <= ST_BUSY;
                            poll_cnt <= 16'd0;
                        end
                    end
                    ST_BUSY: begin
                        if (rx != 8'h00) begin
                            state <= ST_FINISH;
                        end else if (poll_cnt == BUSY_LAST) begin
                            err_code_r <= ERR_BUSY_TIMEOUT;
                            state      <= ST_FINISH;
                        end else begin
                            poll_cnt <= poll_cnt + 16'd1;
                        end
                    end
                    ST_FINISH: begin
                        state   <= ST_IDLE;
                        busy_r  <= 1'b0;
                        sd_cs_r <= 1'b1;
                        done_r  <= 1'b1;
                        err_r   <= (err_code_r != ERR_NONE);
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.err      = err_r;
    assign bus.err_code = err_code_r;
    assign bus.sd_cs    = sd_cs_r;
    assign bus.spi_send = spi_send;
    assign bus.spi_tx   = spi_tx;
    assign bus.rd_data  = rx;
    assign bus.rd_valid = ack && (state == ST_DATA) && !wr_op;
    assign bus.wr_take  = spi_send && (state == ST_DATA) && wr_op;

endmodule

// File: tb/tb_sd_block_ctrl.sv
// Directed bench for sd_block_ctrl: a behavioural SD card answers each SPI
// exchange and monitors tally read strobes, write takes and done pulses.
module tb_sd_block_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sd_block_ctrl_if bus ();

    sd_block_ctrl #(.R1_POLLS(8), .TOKEN_POLLS(16), .BUSY_POLLS(65535)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // card scenario knobs, written only by the stimulus block
    int         r1_fills  = 0;
    bit         r1_never  = 1'b0;
    logic [7:0] r1_val    = 8'h00;
    int         tok_fills = 0;
    bit         tok_never = 1'b0;
    logic [7:0] tok_val   = 8'hFE;
    logic [7:0] resp_val  = 8'hE5;
    int         busy_n    = 0;

    localparam int P_CMD = 0, P_R1 = 1, P_RTOK = 2, P_RDATA = 3, P_RCRC = 4;
    localparam int P_WTOK = 5, P_WDATA = 6, P_WCRC = 7, P_WRESP = 8, P_WBUSY = 9, P_END = 10;

    logic       m_busy = 1'b0;
    logic       m_avail = 1'b0;
    logic [7:0] m_rx = 8'hFF;
    logic [7:0] resp_hold = 8'hFF;
    int         m_delay = 0;
    int         phase = P_CMD;
    logic [2:0] cmd_i = 3'd0;
    logic [7:0] cmd_log [6];
    int r1_i = 0, tok_i = 0, d_i = 0, crc_i = 0, busy_i = 0, trail = 0;
    int gap_ff = 0, wbad = 0, crc_bad = 0, guard_bad = 0, cs_bad = 0;
    logic prev_send = 1'b0;
    logic prev_cs = 1'b1;

    assign bus.spi_busy  = m_busy;
    assign bus.spi_avail = m_avail;
    assign bus.spi_rx    = m_rx;

    // SD card model: answers each byte three cycles after the send pulse
    always @(negedge clk) begin
        m_avail   <= 1'b0;
        prev_send <= bus.spi_send;
        prev_cs   <= bus.sd_cs;
        if (bus.spi_send && (m_busy || prev_send)) guard_bad <= guard_bad + 1;
        if (bus.spi_send && bus.sd_cs) cs_bad <= cs_bad + 1;
        if (m_delay != 0) begin
            m_delay <= m_delay - 1;
            if (m_delay == 1) begin
                m_avail <= 1'b1;
                m_rx    <= resp_hold;
                m_busy  <= 1'b0;
            end
        end
        if (prev_cs && !bus.sd_cs) begin
            phase <= P_CMD; cmd_i <= 3'd0; r1_i <= 0; tok_i <= 0; d_i <= 0; crc_i <= 0;
            busy_i <= 0; trail <= 0; gap_ff <= 0; wbad <= 0; crc_bad <= 0;
        end else if (bus.spi_send) begin
            m_busy    <= 1'b1;
            m_delay   <= 3;
            resp_hold <= 8'hFF;
            case (phase)
                P_CMD: begin
                    cmd_log[cmd_i] <= bus.spi_tx;
                    cmd_i <= cmd_i + 3'd1;
                    if (cmd_i == 3'd5) phase <= P_R1;
                end
                P_R1: begin
                    r1_i <= r1_i + 1;
                    if (!r1_never && r1_i >= r1_fills) begin
                        resp_hold <= r1_val;
                        if (r1_val != 8'h00) phase <= P_END;
                        else phase <= (cmd_log[0] == 8'h58) ? P_WTOK : P_RTOK;
                    end
                end
                P_RTOK: begin
                    tok_i <= tok_i + 1;
                    if (!tok_never && tok_i >= tok_fills) begin
                        resp_hold <= tok_val;
                        phase <= (tok_val == 8'hFE) ? P_RDATA : P_END;
                    end
                end
                P_RDATA: begin
                    resp_hold <= 8'(d_i);
                    d_i <= d_i + 1;
                    if (d_i == 511) phase <= P_RCRC;
                end
                P_RCRC: begin
                    resp_hold <= 8'hA5;
                    crc_i <= crc_i + 1;
                    if (crc_i == 1) phase <= P_END;
                end
                P_WTOK: begin
                    if (bus.spi_tx == 8'hFE) phase <= P_WDATA;
                    else if (bus.spi_tx == 8'hFF) gap_ff <= gap_ff + 1;
                    else wbad <= wbad + 1;
                end
                P_WDATA: begin
                    if (bus.spi_tx != ~8'(d_i)) wbad <= wbad + 1;
                    d_i <= d_i + 1;
                    if (d_i == 511) phase <= P_WCRC;
                end
                P_WCRC: begin
                    if (bus.spi_tx != 8'hFF) crc_bad <= crc_bad + 1;
                    crc_i <= crc_i + 1;
                    if (crc_i == 1) phase <= P_WRESP;
                end
                P_WRESP: begin
                    resp_hold <= resp_val;
                    phase <= ((resp_val & 8'h1F) == 8'h05) ? P_WBUSY : P_END;
                end
                P_WBUSY: begin
                    busy_i <= busy_i + 1;
                    if (busy_i < busy_n) resp_hold <= 8'h00;
                    else phase <= P_END;
                end
                default: trail <= trail + 1;
            endcase
        end
    end

    int rd_cnt = 0, rd_bad = 0, take_cnt = 0, take_nosend = 0, done_cnt = 0;
    logic [7:0] rd_idx = 8'd0;
    logic [7:0] src_idx = 8'd0;
    logic       last_err = 1'b0;
    logic [2:0] last_code = 3'd0;

    assign bus.wr_data = ~src_idx;

    // host-side monitors and the write data source (byte i is ~i)
    always @(negedge clk) begin
        if (bus.sd_cs) begin
            rd_idx  <= 8'd0;
            src_idx <= 8'd0;
        end else begin
            if (bus.rd_valid) begin
                if (bus.rd_data != rd_idx) rd_bad <= rd_bad + 1;
                rd_idx <= rd_idx + 8'd1;
                rd_cnt <= rd_cnt + 1;
            end
            if (bus.wr_take) begin
                src_idx  <= src_idx + 8'd1;
                take_cnt <= take_cnt + 1;
            end
        end
        if (bus.wr_take && !bus.spi_send) take_nosend <= take_nosend + 1;
        if (bus.done) begin
            done_cnt  <= done_cnt + 1;
            last_err  <= bus.err;
            last_code <= bus.err_code;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_start(input logic wr, input logic [31:0] lba, input logic hc);
        @(negedge clk);
        bus.start = 1'b1; bus.write = wr; bus.lba = lba; bus.high_cap = hc;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input logic exp_err, input logic [2:0] exp_code);
        int n;
        int d0;
        n  = 0;
        d0 = done_cnt;
        while (done_cnt == d0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check_output({tag, " done"}, done_cnt - d0, 1);
        check_output({tag, " err"}, last_err, exp_err);
        check_output({tag, " code"}, last_code, exp_code);
        check_output({tag, " cs"}, bus.sd_cs, 1'b1);
        check_output({tag, " busy"}, bus.busy, 1'b0);
    endtask

    int rd0, tk0, dn0, n;

    initial begin
        bus.start = 1'b0; bus.write = 1'b0; bus.lba = 32'h0; bus.high_cap = 1'b0;
        repeat (3) @(negedge clk);
        check_output("rst busy", bus.busy, 1'b0);
        check_output("rst done", bus.done, 1'b0);
        check_output("rst err", bus.err, 1'b0);
        check_output("rst code", bus.err_code, 3'd0);
        check_output("rst rd_valid", bus.rd_valid, 1'b0);
        check_output("rst rd_data", bus.rd_data, 8'h00);
        check_output("rst wr_take", bus.wr_take, 1'b0);
        check_output("rst spi_send", bus.spi_send, 1'b0);
        check_output("rst spi_tx", bus.spi_tx, 8'hFF);
        check_output("rst cs", bus.sd_cs, 1'b1);
        rst = 1'b0;

        // read LBA 0x10, block addressing
        r1_fills = 2; r1_val = 8'h00; tok_fills = 5; tok_val = 8'hFE;
        rd0 = rd_cnt;
        apply_start(1'b0, 32'h0000_0010, 1'b1);
        check_output("rd1 busy", bus.busy, 1'b1);
        check_output("rd1 cs low", bus.sd_cs, 1'b0);
        wait_done("rd1", 1'b0, 3'd0);
        check_output("rd1 cmd0", cmd_log[0], 8'h51);
        check_output("rd1 cmd1", cmd_log[1], 8'h00);
        check_output("rd1 cmd3", cmd_log[3], 8'h00);
        check_output("rd1 cmd4", cmd_log[4], 8'h10);
        check_output("rd1 cmd5", cmd_log[5], 8'hFF);
        check_output("rd1 count", rd_cnt - rd0, 512);
        check_output("rd1 data", rd_bad, 0);
        check_output("rd1 trail", trail, 1);

        // byte addressing LBA 3, with an ignored start while busy
        rd0 = rd_cnt; dn0 = done_cnt;
        apply_start(1'b0, 32'h3, 1'b0);
        repeat (300) @(negedge clk);
        apply_start(1'b1, 32'h55, 1'b1);
        wait_done("rd2", 1'b0, 3'd0);
        check_output("rd2 cmd0", cmd_log[0], 8'h51);
        check_output("rd2 cmd1", cmd_log[1], 8'h00);
        check_output("rd2 cmd2", cmd_log[2], 8'h00);
        check_output("rd2 cmd3", cmd_log[3], 8'h06);
        check_output("rd2 cmd4", cmd_log[4], 8'h00);
        check_output("rd2 count", rd_cnt - rd0, 512);
        repeat (30) @(negedge clk);
        check_output("rd2 no restart", done_cnt - dn0, 1);
        check_output("rd2 idle", bus.busy, 1'b0);

        // write LBA 7, accepted then 100 busy polls
        r1_fills = 1; resp_val = 8'hE5; busy_n = 100;
        tk0 = take_cnt;
        apply_start(1'b1, 32'h7, 1'b1);
        wait_done("wr1", 1'b0, 3'd0);
        check_output("wr1 cmd0", cmd_log[0], 8'h58);
        check_output("wr1 cmd4", cmd_log[4], 8'h07);
        check_output("wr1 takes", take_cnt - tk0, 512);
        check_output("wr1 take w/o send", take_nosend, 0);
        check_output("wr1 gap", gap_ff, 1);
        check_output("wr1 data", wbad, 0);
        check_output("wr1 crc", crc_bad, 0);
        check_output("wr1 crc len", crc_i, 2);
        check_output("wr1 busy polls", busy_i, 101);
        check_output("wr1 trail", trail, 1);

        // R1 never clears bit 7
        r1_never = 1'b1;
        apply_start(1'b0, 32'h1, 1'b1);
        wait_done("r1to", 1'b1, 3'd1);
        check_output("r1to polls", r1_i, 9);
        r1_never = 1'b0;

        // R1 reports an error status
        r1_val = 8'h04;
        apply_start(1'b0, 32'h1, 1'b1);
        wait_done("r1st", 1'b1, 3'd2);
        check_output("r1st trail", trail, 1);
        r1_val = 8'h00;

        // write data rejected
        resp_val = 8'h0B;
        tk0 = take_cnt;
        apply_start(1'b1, 32'h2, 1'b1);
        wait_done("wrej", 1'b1, 3'd5);
        check_output("wrej takes", take_cnt - tk0, 512);
        check_output("wrej trail", trail, 1);

        // error token instead of data
        tok_fills = 3; tok_val = 8'h08;
        rd0 = rd_cnt;
        apply_start(1'b0, 32'h4, 1'b1);
        wait_done("etok", 1'b1, 3'd4);
        check_output("etok reads", rd_cnt - rd0, 0);
        check_output("etok trail", trail, 1);

        // token never arrives
        tok_never = 1'b1;
        apply_start(1'b0, 32'h4, 1'b1);
        wait_done("tokto", 1'b1, 3'd3);
        check_output("tokto polls", tok_i, 17);
        tok_never = 1'b0; tok_val = 8'hFE;

        // reset in the middle of the data phase
        rd0 = rd_cnt; dn0 = done_cnt; n = 0;
        apply_start(1'b0, 32'h9, 1'b1);
        while (rd_cnt - rd0 < 200 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check_output("mid reached 200", (rd_cnt - rd0 >= 200), 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_output("mid cs", bus.sd_cs, 1'b1);
        check_output("mid busy", bus.busy, 1'b0);
        rd0 = rd_cnt;
        repeat (30) @(negedge clk);
        check_output("mid no done", done_cnt - dn0, 0);
        check_output("mid reads stop", rd_cnt - rd0, 0);
        check_output("mid idle cs", bus.sd_cs, 1'b1);

        rd0 = rd_cnt;
        apply_start(1'b0, 32'h9, 1'b1);
        wait_done("after", 1'b0, 3'd0);
        check_output("after count", rd_cnt - rd0, 512);
        check_output("after data", rd_bad, 0);

        check_output("spi guard", guard_bad, 0);
        check_output("send with cs high", cs_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
